// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register chain: STAGES valid/ready stages with flush and occupancy count.
// Optional stall statistics counter enabled by defining PIPE_REG_ELASTIC_STATS_EN.
module pipe_reg_elastic #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned CNT_WIDTH  = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  occupancy
`ifdef PIPE_REG_ELASTIC_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           stall_cycles
`endif
);

    generate
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("pipe_reg_elastic: STAGES must be in 1..16");
        end
    endgenerate

    logic [STAGES-1:0]     valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic [STAGES-1:0]     rdy;
    logic [STAGES-1:0]     up_valid;
    logic [DATA_WIDTH-1:0] up_data [STAGES];

    // Ready is walked from the output end through a scalar carry so the
    // vector never depends combinationally on its own bits.
    always_comb begin
        logic carry;
        carry = out_ready;
        rdy   = '0;
        for (int unsigned j = 0; j < STAGES; j++) begin
            carry                = ~valid_q[STAGES-1-j] | carry;
            rdy[STAGES-1-j]      = carry;
        end
    end

    always_comb begin
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        for (int unsigned i = 1; i < STAGES; i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
                valid_d[i] = up_valid[i];
                if (up_valid[i]) begin
                    data_d[i] = up_data[i];
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            occ_d = occ_d + CNT_WIDTH'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

`ifdef PIPE_REG_ELASTIC_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stats_clr) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Scoreboard bench for pipe_reg_elastic: one instance per STAGES=1..4, words checked in order.
module tb_pipe_reg_elastic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] iv, ir, ov, ordy, fl, sclr;
    logic [7:0] id [4];
    logic [7:0] od [4];
    logic [3:0] occ_ext [4];
    logic [31:0] sc [4];

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CW = $clog2(g + 2);
        logic [CW-1:0] occ_w;
        pipe_reg_elastic #(
            .DATA_WIDTH(8),
            .STAGES(g + 1)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_data  (id[g]),
            .in_ready (ir[g]),
            .out_valid(ov[g]),
            .out_data (od[g]),
            .out_ready(ordy[g]),
            .flush    (fl[g]),
            .occupancy(occ_w)
`ifdef PIPE_REG_ELASTIC_STATS_EN
            ,
            .stats_clr   (sclr[g]),
            .stall_cycles(sc[g])
`endif
        );
        assign occ_ext[g] = 4'(occ_w);
`ifndef PIPE_REG_ELASTIC_STATS_EN
        assign sc[g] = '0;
`endif
    end

    // Scoreboard step: caller has set inputs and waited #1 for the ready chain to settle.
    task automatic advance(input int k);
        logic [7:0] exp;
        int s;
        s = k + 1;
        checks++;
        if (ir[k] !== ((q.size() == s && !ordy[k]) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL sb_in_ready stages=%0d: got %b, model occupancy %0d out_ready %b", s, ir[k], q.size(), ordy[k]);
        end
        checks++;
        if (occ_ext[k] != q.size()) begin
            errors++;
            $display("FAIL sb_occupancy stages=%0d: got %0d expected %0d", s, occ_ext[k], q.size());
        end
        if (ov[k] === 1'b1 && ordy[k]) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_out stages=%0d: got 0x%02h expected no word", s, od[k]);
            end else begin
                exp = q.pop_front();
                delivered++;
                if (od[k] !== exp) begin
                    errors++;
                    $display("FAIL sb_out_data stages=%0d: got 0x%02h expected 0x%02h", s, od[k], exp);
                end
            end
        end
        if (fl[k]) q.delete();
        else if (iv[k] && ir[k]) q.push_back(id[k]);
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int k, input int budget);
        iv[k]   = 1'b0;
        fl[k]   = 1'b0;
        ordy[k] = 1'b1;
        for (int n = 0; n < budget && q.size() > 0; n++) begin
            #1;
            advance(k);
        end
    endtask

    task automatic test_reset();
        int k;
        k = 1;
        iv[k] = 1'b1; ordy[k] = 1'b0;
        id[k] = 8'h5A; #1; advance(k);
        id[k] = 8'h5B; #1; advance(k);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[k] !== 1'b0 || occ_ext[k] !== 4'd0 || od[k] !== 8'h00 || ir[k] !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got ov=%b occ=%0d od=0x%02h ir=%b expected 0 0 0x00 1", ov[k], occ_ext[k], od[k], ir[k]);
        end
        q.delete();
        ordy[k] = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (ov[k] !== 1'b0 || occ_ext[k] !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: got ov=%b occ=%0d expected 0 0", ov[k], occ_ext[k]);
        end
        iv[k] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_stream();
        int k;
        logic [7:0] words  [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] exp_od [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
        logic       exp_ov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        k = 1;
        ordy[k] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            iv[k] = (i < 3);
            id[k] = (i < 3) ? words[i] : 8'h00;
            #1;
            checks++;
            if (ov[k] !== exp_ov[i] || (exp_ov[i] && od[k] !== exp_od[i]) || (i < 2 && od[k] !== exp_od[i]) || ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL stream_w%0d: got ov=%b od=0x%02h ir=%b expected ov=%b od=0x%02h ir=1", i, ov[k], od[k], ir[k], exp_ov[i], exp_od[i]);
            end
            advance(k);
        end
    endtask

    task automatic test_backpressure();
        int k, d0;
        logic [7:0] words [3] = '{8'hA0, 8'hA1, 8'hA2};
        k = 2; d0 = delivered;
        ordy[k] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[k] = 1'b1; id[k] = words[i]; #1;
            advance(k);
        end
        id[k] = 8'hA3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ir[k] !== 1'b0 || occ_ext[k] !== 4'd3 || ov[k] !== 1'b1 || od[k] !== 8'hA0) begin
                errors++;
                $display("FAIL bp_stall%0d: got ir=%b occ=%0d ov=%b od=0x%02h expected 0 3 1 0xa0", i, ir[k], occ_ext[k], ov[k], od[k]);
            end
            advance(k);
        end
        ordy[k] = 1'b1; #1;
        checks++;
        if (ir[k] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", ir[k]);
        end
        advance(k);
        drain(k, 20);
        checks++;
        if (delivered - d0 != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d delivered, %0d pending expected 4, 0", delivered - d0, q.size());
        end
    endtask

    task automatic test_full_throughput();
        int k, d0;
        k = 1; d0 = delivered;
        ordy[k] = 1'b0;
        iv[k] = 1'b1; id[k] = 8'h01; #1; advance(k);
        id[k] = 8'h02; #1; advance(k);
        id[k] = 8'h03; ordy[k] = 1'b1; #1;
        checks++;
        if (ir[k] !== 1'b1 || ov[k] !== 1'b1 || od[k] !== 8'h01 || occ_ext[k] !== 4'd2) begin
            errors++;
            $display("FAIL full_tp_edge: got ir=%b ov=%b od=0x%02h occ=%0d expected 1 1 0x01 2", ir[k], ov[k], od[k], occ_ext[k]);
        end
        advance(k);
        iv[k] = 1'b0; #1;
        checks++;
        if (occ_ext[k] !== 4'd2 || ov[k] !== 1'b1 || od[k] !== 8'h02) begin
            errors++;
            $display("FAIL full_tp_after: got occ=%0d ov=%b od=0x%02h expected 2 1 0x02", occ_ext[k], ov[k], od[k]);
        end
        advance(k);
        drain(k, 20);
        checks++;
        if (delivered - d0 != 3 || q.size() != 0) begin
            errors++;
            $display("FAIL full_tp_count: got %0d delivered, %0d pending expected 3, 0", delivered - d0, q.size());
        end
    endtask

    task automatic test_flush();
        int k, d0;
        k = 3; d0 = delivered;
        ordy[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[k] = 1'b1; id[k] = 8'(8'h40 + i); #1; advance(k);
        end
        id[k] = 8'hFF; fl[k] = 1'b1; ordy[k] = 1'b1; #1;
        checks++;
        if (occ_ext[k] !== 4'd4 || ir[k] !== 1'b1 || ov[k] !== 1'b1 || od[k] !== 8'h40) begin
            errors++;
            $display("FAIL flush_pre: got occ=%0d ir=%b ov=%b od=0x%02h expected 4 1 1 0x40", occ_ext[k], ir[k], ov[k], od[k]);
        end
        advance(k);
        fl[k] = 1'b0; iv[k] = 1'b0; #1;
        checks++;
        if (occ_ext[k] !== 4'd0 || ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: got occ=%0d ov=%b expected 0 0", occ_ext[k], ov[k]);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ov[k] !== 1'b0) begin
                errors++;
                $display("FAIL flush_dropped%0d: got ov=%b od=0x%02h expected ov=0", i, ov[k], od[k]);
            end
            advance(k);
        end
        checks++;
        if (delivered - d0 != 1) begin
            errors++;
            $display("FAIL flush_count: got %0d delivered expected 1", delivered - d0);
        end
    endtask

    task automatic test_stages1();
        int k, d0, w;
        logic prev_stall;
        logic [7:0] prev_od;
        k = 0; d0 = delivered; w = 0; prev_stall = 1'b0; prev_od = 8'h00;
        for (int n = 0; n < 60 && (delivered - d0) < 8; n++) begin
            ordy[k] = (n % 2 == 0);
            iv[k]   = (w < 8);
            id[k]   = 8'(w);
            #1;
            if (prev_stall) begin
                checks++;
                if (ov[k] !== 1'b1 || od[k] !== prev_od) begin
                    errors++;
                    $display("FAIL s1_stable_n%0d: got ov=%b od=0x%02h expected 1 0x%02h", n, ov[k], od[k], prev_od);
                end
            end
            prev_stall = ov[k] && !ordy[k];
            prev_od    = od[k];
            if (iv[k] && ir[k]) w++;
            advance(k);
        end
        iv[k] = 1'b0;
        checks++;
        if (delivered - d0 != 8 || q.size() != 0) begin
            errors++;
            $display("FAIL s1_count: got %0d delivered, %0d pending expected 8, 0", delivered - d0, q.size());
        end
    endtask

`ifdef PIPE_REG_ELASTIC_STATS_EN
    task automatic test_stats();
        int k;
        k = 1;
        ordy[k] = 1'b0; sclr[k] = 1'b1;
        iv[k] = 1'b1; id[k] = 8'h55; #1; advance(k);
        iv[k] = 1'b0; #1; advance(k);
        sclr[k] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if (ov[k] !== 1'b1) begin
                errors++;
                $display("FAIL stats_stall%0d: got ov=%b expected 1", i, ov[k]);
            end
            advance(k);
        end
        #1;
        checks++;
        if (sc[k] !== 32'd7) begin
            errors++;
            $display("FAIL stats_count: got %0d expected 7", sc[k]);
        end
        sclr[k] = 1'b1;
        advance(k);
        sclr[k] = 1'b0; #1;
        checks++;
        if (sc[k] !== 32'd0) begin
            errors++;
            $display("FAIL stats_clr: got %0d expected 0", sc[k]);
        end
        advance(k);
        #1;
        checks++;
        if (sc[k] !== 32'd1) begin
            errors++;
            $display("FAIL stats_resume: got %0d expected 1", sc[k]);
        end
        drain(k, 20);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv = '0; ordy = '0; fl = '0; sclr = '0;
        for (int i = 0; i < 4; i++) id[i] = 8'h00;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_throughput();
        test_flush();
        test_stages1();
`ifdef PIPE_REG_ELASTIC_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
